tmr_vote_monitor: RTL and testbench
===================================

Name: tmr_vote_monitor

Overview:
Downstream consumer of a triplicated combinational stage. It takes the three replica buses inA/inB/inC, performs a registered bitwise majority vote, and reports which replica disagrees. A per-replica persistence FSM separates transient upsets (SEU) from stuck replicas. The voted output and the health flags feed the next single-copy pipeline stage and the slow-control status registers.

Parameters:
WIDTH, 8, bit width of each replica bus and of the voted output
PERSIST, 4, consecutive mismatching valid cycles before a replica is declared FAILED (legal range 2..15)
CNT_W, 8, width of the saturating mismatch event counter (optional feature only)

Ports:
clk  input  1  single clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
inA  input  WIDTH  replica A data
inB  input  WIDTH  replica B data
inC  input  WIDTH  replica C data
validIn  input  1  replica data valid this cycle (single, already-voted strobe)
clrErr  input  1  synchronous clear of sticky flags and counters
out  output  WIDTH  registered bitwise majority of inA/inB/inC
validOut  output  1  out/errChan valid, validIn delayed by 1 cycle
errChan  output  3  {C,B,A}, one-hot or multi-hot, replica whose word differed from the vote on the last valid cycle
multiErr  output  1  two or more replicas disagreed on the last valid cycle
failedChan  output  3  sticky {C,B,A}, replica declared FAILED
errCnt  output  CNT_W  saturating count of valid cycles with any mismatch

Behaviour:
- Reset (rstn low, asynchronous): out=0, validOut=0, errChan=0, multiErr=0, failedChan=0, errCnt=0, all FSMs in OK, persistence counters 0. Release is synchronous to clk.
- Vote: v[i] = (A&B)|(A&C)|(B&C) per bit, combinational.
- Latency: exactly 1 cycle. On a validIn cycle, out<=v, validOut<=1, errChan[x]<=(inX!=v), multiErr<=(popcount(errChan_next)>=2).
- On a non-valid cycle: validOut<=0; out, errChan and multiErr hold their previous values. FSMs and counters do not advance.
- Per-replica FSM (x in A,B,C), evaluated only on validIn cycles:
  - OK: if mismatch, go to SUSPECT with pcnt=1; else stay.
  - SUSPECT: if mismatch and pcnt+1==PERSIST, go to FAILED and set failedChan[x]; if mismatch otherwise, pcnt++; if match, go to OK with pcnt=0.
  - FAILED: absorbing; failedChan[x] stays 1 and mismatches are ignored by the FSM.
- clrErr (sampled every cycle, independent of validIn): all FSMs to OK, pcnt=0, failedChan=0, errCnt=0.
  - clrErr has priority over a same-cycle mismatch. That cycle's mismatch is not counted in pcnt or errCnt.
  - errChan, multiErr, out and validOut still update normally on that cycle.
- All three replicas pairwise different in one bit: the vote still resolves per bit and multiErr=1. No uncorrectable state exists for a bitwise vote.
- A FAILED replica still participates in the vote. Masking is the system's decision, not this block's.
- Reset mid-operation: everything returns to reset values immediately. No output pulse on release.

Optional Feature:
TMR_VOTE_MONITOR_ERRCNT_EN
- Defined: errCnt increments by 1 on every validIn cycle with |errChan_next and no clrErr. It saturates at 2^CNT_W-1 and never wraps.
- Undefined: errCnt is tied to 0, no counter flops are built, and CNT_W is ignored. All other behaviour is identical.

Test Plan:
- Reset, then validIn=1 with A=B=C=8'h5A -> next cycle: out=8'h5A, validOut=1, errChan=0, multiErr=0, failedChan=0.
- A=8'h5B, B=C=8'h5A for 1 valid cycle, then all equal -> out=8'h5A, errChan=3'b001 for one cycle, FSM A returns to OK, failedChan=0. With macro defined, errCnt=1.
- A=8'hFF, B=C=8'h00 for PERSIST=4 consecutive valid cycles -> failedChan=3'b001 after the 4th sample. A further 2 valid cycles, including idle gaps, keep it set. out=8'h00 throughout.
- A=8'h01, B=8'h02, C=8'h00 -> out=8'h00, errChan=3'b011, multiErr=1.
- Mismatch on C with clrErr=1 in the same cycle -> errChan=3'b100, failedChan=0, errCnt unchanged at 0. Three further C mismatches do not yet set failedChan[2]; the fourth does.
- Macro defined, CNT_W=2, 5 mismatching valid cycles -> errCnt reads 3 and holds. Assert rstn low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/tmr_vote_monitor.sv
// Registered bitwise TMR voter with per-replica SEU/stuck discrimination.
// Optional saturating mismatch counter enabled by TMR_VOTE_MONITOR_ERRCNT_EN.
module tmr_vote_monitor #(
    parameter int WIDTH   = 8,
    parameter int PERSIST = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [WIDTH-1:0] inC,
    input  logic             validIn,
    input  logic             clrErr,
    output logic [WIDTH-1:0] out,
    output logic             validOut,
    output logic [2:0]       errChan,
    output logic             multiErr,
    output logic [2:0]       failedChan,
    output logic [CNT_W-1:0] errCnt
);

    typedef enum logic [1:0] {
        OK      = 2'd0,
        SUSPECT = 2'd1,
        FAILED  = 2'd2
    } chanState_e;

    localparam logic [3:0] PERSIST_L = 4'(PERSIST);

    logic [WIDTH-1:0] vote_p0;
    logic [2:0]       errChanNext_p0;
    logic             multiNext_p0;

    chanState_e state_p1 [3];
    chanState_e stateNext_p0 [3];
    logic [3:0] pcnt_p1 [3];
    logic [3:0] pcntNext_p0 [3];

    // Stage p0: combinational vote and per-replica disagreement
    always_comb begin
        vote_p0        = (inA & inB) | (inA & inC) | (inB & inC);
        errChanNext_p0 = {inC != vote_p0, inB != vote_p0, inA != vote_p0};
        multiNext_p0   = (errChanNext_p0[0] & errChanNext_p0[1]) |
                         (errChanNext_p0[0] & errChanNext_p0[2]) |
                         (errChanNext_p0[1] & errChanNext_p0[2]);
    end

    // Stage p1: voted word and error flags hold across idle cycles
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out      <= '0;
            validOut <= 1'b0;
            errChan  <= 3'b000;
            multiErr <= 1'b0;
        end else begin
            validOut <= validIn;
            if (validIn) begin
                out      <= vote_p0;
                errChan  <= errChanNext_p0;
                multiErr <= multiNext_p0;
            end
        end
    end

    // Persistence FSM: a clear wins over any same-cycle mismatch
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            stateNext_p0[i] = state_p1[i];
            pcntNext_p0[i]  = pcnt_p1[i];
            if (clrErr) begin
                stateNext_p0[i] = OK;
                pcntNext_p0[i]  = 4'd0;
            end else if (validIn) begin
                case (state_p1[i])
                    OK: begin
                        if (errChanNext_p0[i]) begin
                            stateNext_p0[i] = SUSPECT;
                            pcntNext_p0[i]  = 4'd1;
                        end
                    end
                    SUSPECT: begin
                        if (errChanNext_p0[i]) begin
                            if (pcnt_p1[i] + 4'd1 == PERSIST_L) begin
                                stateNext_p0[i] = FAILED;
                            end else begin
                                pcntNext_p0[i] = pcnt_p1[i] + 4'd1;
                            end
                        end else begin
                            stateNext_p0[i] = OK;
                            pcntNext_p0[i]  = 4'd0;
                        end
                    end
                    FAILED: begin
                    end
                    default: begin
                        stateNext_p0[i] = OK;
                        pcntNext_p0[i]  = 4'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 3; i++) begin
                state_p1[i] <= OK;
                pcnt_p1[i]  <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_p1[i] <= stateNext_p0[i];
                pcnt_p1[i]  <= pcntNext_p0[i];
            end
        end
    end

    assign failedChan = {state_p1[2] == FAILED, state_p1[1] == FAILED, state_p1[0] == FAILED};

`ifdef TMR_VOTE_MONITOR_ERRCNT_EN
    logic [CNT_W-1:0] errCnt_p1;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            errCnt_p1 <= '0;
        end else if (clrErr) begin
            errCnt_p1 <= '0;
        end else if (validIn && (|errChanNext_p0)) begin
            errCnt_p1 <= satInc(errCnt_p1);
        end
    end

    assign errCnt = errCnt_p1;
`else
    assign errCnt = '0;
`endif

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Bench for tmr_vote_monitor: directed steps plus random replicas against a run-length model.
module tb_tmr_vote_monitor;

    localparam int WIDTH   = 8;
    localparam int PERSIST = 4;
    localparam int CNT_W   = 2;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [WIDTH-1:0] inA = '0, inB = '0, inC = '0;
    logic             validIn = 1'b0;
    logic             clrErr = 1'b0;
    logic [WIDTH-1:0] out;
    logic             validOut;
    logic [2:0]       errChan;
    logic             multiErr;
    logic [2:0]       failedChan;
    logic [CNT_W-1:0] errCnt;

    tmr_vote_monitor #(.WIDTH(WIDTH), .PERSIST(PERSIST), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .inA(inA), .inB(inB), .inC(inC),
        .validIn(validIn), .clrErr(clrErr), .out(out), .validOut(validOut),
        .errChan(errChan), .multiErr(multiErr), .failedChan(failedChan), .errCnt(errCnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int stepNo = 0;

    // Reference state: expected outputs plus consecutive-mismatch run length per replica
    logic [WIDTH-1:0] expOut;
    logic             expValid;
    logic [2:0]       expErr;
    logic             expMulti;
    logic [2:0]       expFailed;
    int               run [3];
    int               expCnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, stepNo, obs, exp);
        end
    endtask

    task automatic checkAll();
        chk("out", 32'(out), 32'(expOut));
        chk("validOut", 32'(validOut), 32'(expValid));
        chk("errChan", 32'(errChan), 32'(expErr));
        chk("multiErr", 32'(multiErr), 32'(expMulti));
        chk("failedChan", 32'(failedChan), 32'(expFailed));
`ifdef TMR_VOTE_MONITOR_ERRCNT_EN
        chk("errCnt", 32'(errCnt), 32'(expCnt));
`else
        chk("errCnt", 32'(errCnt), 32'd0);
`endif
    endtask

    task automatic modelReset();
        expOut = '0; expValid = 1'b0; expErr = 3'b000; expMulti = 1'b0;
        expFailed = 3'b000; expCnt = 0;
        for (int i = 0; i < 3; i++) run[i] = 0;
    endtask

    task automatic modelClock(input logic [WIDTH-1:0] a, b, c, input logic v, clr);
        logic [WIDTH-1:0] vt;
        logic [WIDTH-1:0] w [3];
        logic [2:0] mis;
        int nMis;
        w[0] = a; w[1] = b; w[2] = c;
        for (int j = 0; j < WIDTH; j++) begin
            int ones;
            ones = int'(a[j]) + int'(b[j]) + int'(c[j]);
            vt[j] = (ones >= 2);
        end
        nMis = 0;
        for (int i = 0; i < 3; i++) begin
            mis[i] = (w[i] != vt);
            nMis += int'(mis[i]);
        end
        expValid = v;
        if (v) begin
            expOut = vt; expErr = mis; expMulti = (nMis >= 2);
            if (!clr) begin
                for (int i = 0; i < 3; i++) begin
                    if (!expFailed[i]) begin
                        run[i] = mis[i] ? run[i] + 1 : 0;
                        if (run[i] == PERSIST) expFailed[i] = 1'b1;
                    end
                end
                if (nMis > 0 && expCnt < (1 << CNT_W) - 1) expCnt++;
            end
        end
        if (clr) begin
            expFailed = 3'b000; expCnt = 0;
            for (int i = 0; i < 3; i++) run[i] = 0;
        end
    endtask

    task automatic step(input logic [WIDTH-1:0] a, b, c, input logic v, clr);
        @(negedge clk);
        inA = a; inB = b; inC = c; validIn = v; clrErr = clr;
        @(posedge clk);
        modelClock(a, b, c, v, clr);
        #1;
        stepNo++;
        checkAll();
    endtask

    initial begin
        modelReset();
        repeat (3) @(posedge clk);
        #1 checkAll();
        @(negedge clk) rstn = 1'b1;

        // Clean agreement, then single transient on A
        step(8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b0);
        step(8'h5B, 8'h5A, 8'h5A, 1'b1, 1'b0);
        step(8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b0);
        step(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0);

        // Stuck A for PERSIST cycles, then idle gaps and further mismatches
        repeat (PERSIST) step(8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
        step(8'hFF, 8'h00, 8'h00, 1'b0, 1'b0);
        step(8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
        step(8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
        step(8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);

        // Three-way pairwise disagreement
        step(8'h01, 8'h02, 8'h00, 1'b1, 1'b0);
        step(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);

        // Clear on the same cycle as a C mismatch; four more needed to fail C
        step(8'h33, 8'h33, 8'hCC, 1'b1, 1'b1);
        repeat (3) step(8'h33, 8'h33, 8'hCC, 1'b1, 1'b0);
        step(8'h33, 8'h33, 8'hCC, 1'b1, 1'b0);
        repeat (3) step(8'h33, 8'hB3, 8'h33, 1'b1, 1'b0);

        // Asynchronous reset mid-stream, no pulse on release
        @(negedge clk);
        #2 rstn = 1'b0;
        modelReset();
        #1 checkAll();
        @(negedge clk);
        validIn = 1'b0; clrErr = 1'b0;
        rstn = 1'b1;
        step(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        // Randomized replicas with occasional stuck episodes and clears
        for (int n = 0; n < 400; n++) begin
            logic [WIDTH-1:0] base, a, b, c;
            logic v, clr;
            base = WIDTH'($urandom);
            a = base; b = base; c = base;
            if ($urandom_range(0, 3) == 0) a = base ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
            if ($urandom_range(0, 3) == 0) b = WIDTH'($urandom);
            if ($urandom_range(0, 5) == 0) c = ~base;
            if ((n / 40) % 3 == 1) b = ~base;
            v = ($urandom_range(0, 9) < 8);
            clr = ($urandom_range(0, 49) == 0);
            step(a, b, c, v, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
